// File: rtl/gpio_pkg.sv
// ---------------------------------------------------------------------------
// gpio_pkg
// Shared constants and types for the GPIO APB front-end.
//   - REGSEL_* : encodings of the GPIO register-select bus
//   - OFF_*    : APB word offsets (paddr[4:2]) of the register map
//   - ST_*     : front-end FSM state encodings
//   - rmw_op_t : atomic PORT operation performed by the RMW sequence
// ---------------------------------------------------------------------------
package gpio_pkg;

    localparam logic [1:0] REGSEL_PIN  = 2'b00;
    localparam logic [1:0] REGSEL_DIR  = 2'b10;
    localparam logic [1:0] REGSEL_PORT = 2'b11;

    localparam logic [2:0] OFF_PIN  = 3'd0;
    localparam logic [2:0] OFF_DIR  = 3'd1;
    localparam logic [2:0] OFF_PORT = 3'd2;
    localparam logic [2:0] OFF_SET  = 3'd3;
    localparam logic [2:0] OFF_CLR  = 3'd4;
    localparam logic [2:0] OFF_TGL  = 3'd5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD_REQ  = 3'd2;
    localparam logic [2:0] ST_RD_DONE = 3'd3;
    localparam logic [2:0] ST_RMW_RD  = 3'd4;
    localparam logic [2:0] ST_RMW_CAP = 3'd5;
    localparam logic [2:0] ST_RMW_WR  = 3'd6;
    localparam logic [2:0] ST_ERR     = 3'd7;

    typedef enum logic [1:0] {
        RMW_SET = 2'd0,
        RMW_CLR = 2'd1,
        RMW_TGL = 2'd2
    } rmw_op_t;

endpackage

// File: rtl/gpio_apb_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_apb_ctrl_if
// APB3 bus bundle between the shared APB master and the GPIO front-end.
//   psel, penable, pwrite, paddr, pwdata : master -> slave
//   prdata, pready, pslverr              : slave  -> master
// ---------------------------------------------------------------------------
interface gpio_apb_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/gpio_apb_decode.sv
// ---------------------------------------------------------------------------
// gpio_apb_decode
// Combinational register-map decode of one APB setup phase.
//   offset_i     : word offset paddr[4:2]
//   addr_hi_nz_i : any address bit above the register window is set
//   write_i      : transfer direction (1 = write)
//   regsel_o     : GPIO register targeted by the transfer
//   is_rmw_o     : transfer is an atomic PORT set/clear/toggle
//   rmw_op_o     : which atomic operation
//   err_o        : transfer must be answered with pslverr
// ---------------------------------------------------------------------------
module gpio_apb_decode
    import gpio_pkg::*;
(
    input  logic [2:0] offset_i,
    input  logic       addr_hi_nz_i,
    input  logic       write_i,
    output logic [1:0] regsel_o,
    output logic       is_rmw_o,
    output rmw_op_t    rmw_op_o,
    output logic       err_o
);

    // NOTE: every output gets a default before the case; a path that leaves
    // one unassigned would infer a latch.
    always_comb begin
        regsel_o = REGSEL_PIN;
        is_rmw_o = 1'b0;
        rmw_op_o = RMW_SET;
        err_o    = 1'b0;
        case (offset_i)
            OFF_PIN:  begin regsel_o = REGSEL_PIN;  err_o = write_i; end
            OFF_DIR:  regsel_o = REGSEL_DIR;
            OFF_PORT: regsel_o = REGSEL_PORT;
            OFF_SET:  begin
                regsel_o = REGSEL_PORT; is_rmw_o = 1'b1;
                rmw_op_o = RMW_SET;     err_o    = !write_i;
            end
            OFF_CLR:  begin
                regsel_o = REGSEL_PORT; is_rmw_o = 1'b1;
                rmw_op_o = RMW_CLR;     err_o    = !write_i;
            end
            OFF_TGL:  begin
                regsel_o = REGSEL_PORT; is_rmw_o = 1'b1;
                rmw_op_o = RMW_TGL;     err_o    = !write_i;
            end
            default:  err_o = 1'b1;
        endcase
        if (addr_hi_nz_i) begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/gpio_apb_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_apb_ctrl
// APB3 slave front-end for the 8-bit GPIO (DIR/PORT/PIN). Turns each APB
// transfer into timed GPIO strobe/select cycles, inserts PREADY wait states
// for the GPIO read latency and implements atomic PORT set/clear/toggle as an
// internal read-modify-write.
//   clk, rst_n    : clock, asynchronous active-low reset
//   apb           : APB3 slave port (prdata is registered)
//   gpio_busw_o   : GPIO write strobe, one cycle per write
//   gpio_regsel_o : GPIO register select (00 PIN, 10 DIR, 11 PORT)
//   gpio_wdata_o  : GPIO write data
//   gpio_rdata_i  : GPIO read data for the currently selected register
//   busy_o        : a transfer sequence is in progress
// ---------------------------------------------------------------------------
module gpio_apb_ctrl
    import gpio_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_apb_ctrl_if.slave    apb,
    output logic              gpio_busw_o,
    output logic [1:0]        gpio_regsel_o,
    output logic [DATA_W-1:0] gpio_wdata_o,
    input  logic [DATA_W-1:0] gpio_rdata_i,
    output logic              busy_o
);

    logic [2:0]        state_q, state_d;
    logic [1:0]        regsel_q;
    rmw_op_t           op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rmw_q;
    logic [DATA_W-1:0] prdata_q;
    logic [DATA_W-1:0] rmw_result;

    logic       setup;
    logic [1:0] dec_regsel;
    logic       dec_is_rmw;
    rmw_op_t    dec_op;
    logic       dec_err;
    logic       unused_paddr_bits;

    // A transfer only launches on a genuine APB setup phase; an access phase
    // seen in IDLE without a preceding setup is ignored.
    assign setup             = apb.psel && !apb.penable;
    // Byte-lane bits carry no meaning for byte-wide word registers.
    assign unused_paddr_bits = ^apb.paddr[1:0];

    gpio_apb_decode u_decode (
        .offset_i     (apb.paddr[4:2]),
        .addr_hi_nz_i (|apb.paddr[ADDR_W-1:5]),
        .write_i      (apb.pwrite),
        .regsel_o     (dec_regsel),
        .is_rmw_o     (dec_is_rmw),
        .rmw_op_o     (dec_op),
        .err_o        (dec_err)
    );

    always_comb begin
        case (op_q)
            RMW_SET: rmw_result = gpio_rdata_i | wdata_q;
            RMW_CLR: rmw_result = gpio_rdata_i & ~wdata_q;
            RMW_TGL: rmw_result = gpio_rdata_i ^ wdata_q;
            default: rmw_result = gpio_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    if (dec_err)          state_d = ST_ERR;
                    else if (!apb.pwrite) state_d = ST_RD_REQ;
                    else if (dec_is_rmw)  state_d = ST_RMW_RD;
                    else                  state_d = ST_WR;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_DONE;
            ST_RMW_RD:  state_d = ST_RMW_CAP;
            ST_RMW_CAP: state_d = ST_RMW_WR;
            // WR, RD_DONE, RMW_WR and ERR all complete the transfer.
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            regsel_q <= REGSEL_PIN;
            op_q     <= RMW_SET;
            wdata_q  <= '0;
            rmw_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && setup) begin
                regsel_q <= dec_regsel;
                op_q     <= dec_op;
                wdata_q  <= apb.pwdata;
            end
            // Captured on the edge entering RD_DONE so it is on prdata while
            // pready is high.
            if (state_q == ST_RD_REQ) begin
                prdata_q <= gpio_rdata_i;
            end
            if (state_q == ST_RMW_CAP) begin
                rmw_q <= rmw_result;
            end
        end
    end

    // Moore outputs, decoded from the state alone.
    always_comb begin
        gpio_busw_o   = 1'b0;
        gpio_regsel_o = REGSEL_PIN;
        gpio_wdata_o  = '0;
        case (state_q)
            ST_WR: begin
                gpio_busw_o   = 1'b1;
                gpio_regsel_o = regsel_q;
                gpio_wdata_o  = wdata_q;
            end
            ST_RD_REQ, ST_RD_DONE: gpio_regsel_o = regsel_q;
            ST_RMW_RD, ST_RMW_CAP: gpio_regsel_o = REGSEL_PORT;
            ST_RMW_WR: begin
                gpio_busw_o   = 1'b1;
                gpio_regsel_o = REGSEL_PORT;
                gpio_wdata_o  = rmw_q;
            end
            default: ;
        endcase
    end

    assign apb.pready  = (state_q == ST_WR)     || (state_q == ST_RD_DONE) ||
                         (state_q == ST_RMW_WR) || (state_q == ST_ERR);
    assign apb.pslverr = (state_q == ST_ERR);
    assign apb.prdata  = prdata_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_apb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_apb_ctrl
// Self-checking bench for gpio_apb_ctrl: a GPIO stand-in, an APB driver that
// pushes expected responses into a scoreboard queue, and a monitor that pops
// and compares whenever the DUT raises pready.
// ---------------------------------------------------------------------------
module tb_gpio_apb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       gpio_busw;
    logic [1:0] gpio_regsel;
    logic [7:0] gpio_wdata;
    logic [7:0] gpio_rdata;
    logic       busy;

    gpio_apb_ctrl_if #(.ADDR_W(8), .DATA_W(8)) apb_if ();

    gpio_apb_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .apb           (apb_if),
        .gpio_busw_o   (gpio_busw),
        .gpio_regsel_o (gpio_regsel),
        .gpio_wdata_o  (gpio_wdata),
        .gpio_rdata_i  (gpio_rdata),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    // GPIO peripheral stand-in (not reset by the front-end reset).
    logic [7:0] g_dir  = 8'h00;
    logic [7:0] g_port = 8'h00;
    logic [7:0] ext_pins = 8'h00;

    always @(posedge clk) begin
        if (gpio_busw && gpio_regsel == 2'b10) g_dir  <= gpio_wdata;
        if (gpio_busw && gpio_regsel == 2'b11) g_port <= gpio_wdata;
    end

    assign gpio_rdata = (gpio_regsel == 2'b10) ? g_dir :
                        (gpio_regsel == 2'b11) ? g_port :
                        ((ext_pins & ~g_dir) | (g_port & g_dir));

    // Scoreboard
    typedef struct {
        int         waits;
        logic       err;
        logic [7:0] rdata;
        int         nbusw;
        logic [1:0] wsel;
        logic [7:0] wdat;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   busw_total = 0;
    int   exp_busw_total = 0;
    bit   xfer_active = 1'b0;

    // Reference model state
    logic [7:0] m_dir = 8'h00;
    logic [7:0] m_port = 8'h00;
    logic [7:0] m_prdata = 8'h00;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: accumulates per-transfer observations, compares on pready.
    initial begin
        int         waits = 0;
        int         nb = 0;
        logic [1:0] sel = 2'b00;
        logic [7:0] dat = 8'h00;
        bit         busy_bad = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && gpio_busw) busw_total++;
            if (xfer_active && apb_if.psel) begin
                if (!apb_if.penable && busy) busy_bad = 1'b1;
                if (apb_if.penable && !busy) busy_bad = 1'b1;
                if (apb_if.penable) begin
                    if (gpio_busw) begin
                        nb++;
                        sel = gpio_regsel;
                        dat = gpio_wdata;
                    end
                    if (!apb_if.pready) begin
                        waits++;
                    end else if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL scoreboard: pready with no expected transfer");
                    end else begin
                        e = sb_q.pop_front();
                        check("waits", waits, e.waits);
                        check("pslverr", apb_if.pslverr, e.err);
                        check("prdata", apb_if.prdata, e.rdata);
                        check("busw_pulses", nb, e.nbusw);
                        check("busy", busy_bad, 0);
                        if (e.nbusw == 1) begin
                            check("wr_regsel", sel, e.wsel);
                            check("wr_wdata", dat, e.wdat);
                        end
                        waits = 0; nb = 0; busy_bad = 1'b0;
                    end
                end
            end
        end
    end

    // Model: computes the expected response from the register-map rules.
    task automatic issue(input bit wr, input logic [7:0] addr, input logic [7:0] data);
        exp_t       e;
        logic [2:0] off;
        logic       err;
        off = addr[4:2];
        err = (addr[7:5] != 3'd0) || (off > 3'd5) || (wr && off == 3'd0) || (!wr && off >= 3'd3);
        e.err = err; e.nbusw = 0; e.wsel = 2'b00; e.wdat = 8'h00; e.waits = 0;
        if (err) begin
            e.waits = 0;
        end else if (!wr) begin
            e.waits = 1;
            if (off == 3'd0)      m_prdata = (ext_pins & ~m_dir) | (m_port & m_dir);
            else if (off == 3'd1) m_prdata = m_dir;
            else                  m_prdata = m_port;
        end else if (off == 3'd1) begin
            m_dir = data; e.nbusw = 1; e.wsel = 2'b10; e.wdat = data;
        end else begin
            if (off == 3'd2)      m_port = data;
            else if (off == 3'd3) m_port = m_port | data;
            else if (off == 3'd4) m_port = m_port & ~data;
            else                  m_port = m_port ^ data;
            e.waits = (off == 3'd2) ? 0 : 2;
            e.nbusw = 1; e.wsel = 2'b11; e.wdat = m_port;
        end
        e.rdata = m_prdata;
        exp_busw_total += e.nbusw;
        sb_q.push_back(e);
    endtask

    // Driver: called 1 time unit after a rising edge; returns likewise, so
    // consecutive calls produce back-to-back APB transfers.
    task automatic xfer(input bit wr, input logic [7:0] addr, input logic [7:0] data);
        int n = 0;
        issue(wr, addr, data);
        xfer_active    = 1'b1;
        apb_if.psel    = 1'b1;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = wr;
        apb_if.paddr   = addr;
        apb_if.pwdata  = data;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!apb_if.pready && n < 16);
        if (!apb_if.pready) begin
            tests++;
            fails++;
            $display("FAIL pready_timeout: addr 0x%0h waited %0d cycles, required pready", addr, n);
        end
        @(posedge clk); #1;
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        xfer_active    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pready"},  apb_if.pready,  0);
        check({tag, "_pslverr"}, apb_if.pslverr, 0);
        check({tag, "_prdata"},  apb_if.prdata,  0);
        check({tag, "_busw"},    gpio_busw,      0);
        check({tag, "_regsel"},  gpio_regsel,    0);
        check({tag, "_wdata"},   gpio_wdata,     0);
        check({tag, "_busy"},    busy,           0);
    endtask

    initial begin
        apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
        apb_if.paddr = 8'h00; apb_if.pwdata = 8'h00;
        #1;
        check_reset_outputs("reset");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // DIR write then read
        xfer(1, 8'h04, 8'hF0);
        xfer(0, 8'h04, 8'h00);
        idle(1);

        // PORT and atomic operations
        xfer(1, 8'h08, 8'h0F);
        xfer(1, 8'h0C, 8'h30);
        xfer(1, 8'h10, 8'h03);
        xfer(1, 8'h14, 8'hFF);
        xfer(0, 8'h08, 8'h00);
        #1 check("plan_port_rmw", apb_if.prdata, 8'hC3);
        idle(1);

        // PIN read with all pins inputs
        xfer(1, 8'h04, 8'h00);
        ext_pins = 8'hA5;
        xfer(0, 8'h00, 8'h00);
        idle(1);

        // Error decodes, then confirm DIR/PORT untouched
        xfer(1, 8'h00, 8'h12);
        xfer(0, 8'h0C, 8'h00);
        xfer(0, 8'h18, 8'h00);
        xfer(1, 8'h18, 8'h77);
        xfer(1, 8'h20, 8'h34);
        xfer(0, 8'h24, 8'h00);
        xfer(0, 8'h04, 8'h00);
        xfer(0, 8'h08, 8'h00);
        idle(1);

        // Back-to-back write/read
        xfer(1, 8'h08, 8'h55);
        xfer(0, 8'h08, 8'h00);
        idle(1);

        // Access phase without setup is ignored
        apb_if.psel = 1'b1; apb_if.penable = 1'b1; apb_if.pwrite = 1'b1;
        apb_if.paddr = 8'h08; apb_if.pwdata = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            check("spurious_pready", apb_if.pready, 0);
            check("spurious_busy", busy, 0);
        end
        @(posedge clk); #1;
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
        idle(1);

        // Reset during RMW_CAP of SET 0xFF with PORT=0x00
        xfer(1, 8'h04, 8'hF0);
        xfer(1, 8'h08, 8'h00);
        xfer(0, 8'h04, 8'h00);
        apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
        apb_if.paddr = 8'h0C; apb_if.pwdata = 8'hFF;
        @(posedge clk); #1;
        apb_if.penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rmw_reset");
        apb_if.psel = 1'b0; apb_if.penable = 1'b0;
        m_prdata = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        xfer(0, 8'h08, 8'h00);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [2:0] hi;
            logic [7:0] addr;
            hi = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            addr = {hi, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            ext_pins = 8'($urandom);
            xfer(1'($urandom_range(0, 1)), addr, 8'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(2);
        check("busw_total", busw_total, exp_busw_total);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
